// File: rtl/axis_exp_adc_emu_pkg.sv
// Shared constants and types for the experiment-ADC SPI emulator.
// Word widths, register-mode control words and the frame state machine encoding.
package axis_exp_adc_pkg;

  localparam int DataWidth = 32;
  localparam int RegWidth  = 24;

  localparam logic [RegWidth-1:0] ExitReg      = {1'b1, 15'h0014, 8'h01};
  localparam logic [2:0]          RegModeEnter = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CLASSIFY
  } state_t;

  // Number of sck edges in a conversion frame for a given lane count.
  function automatic logic [5:0] conv_edges(input int num_sdi);
    return 6'(DataWidth / num_sdi);
  endfunction

endpackage

// File: rtl/axis_exp_adc_emu_if.sv
// AXI Stream channel used for the conversion-word input and register-word output.
interface axis_exp_adc_emu_if
  import axis_exp_adc_pkg::*;
#(
  parameter int Width = DataWidth
) ();

  logic [Width-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_exp_adc_emu_spi_sync_edge.sv
// Two-flop synchronizer with an edge-detect stage and registered rise/fall pulses.
// The level output is aligned with the pulses so several instances stay mutually in step.
module spi_sync_edge (
  input  logic aclk,
  input  logic aresetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // Reset to 0 so a chip select that is already low when reset releases never looks like a fall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/axis_exp_adc_emu.sv
// SPI responder standing in for the multi-lane experiment ADC: serves conversion words
// from s_axis on NUM_SDI lanes and forwards captured 24-bit register words on m_axis.
module axis_exp_adc_emu
  import axis_exp_adc_pkg::*;
#(
  parameter int NUM_SDI = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               spi_csn,
  input  logic               spi_sck,
  input  logic               spi_sdo,
  output logic [NUM_SDI-1:0] spi_sdi,
  axis_exp_adc_emu_if.slave  s_axis,
  axis_exp_adc_emu_if.master m_axis,
  output logic               reg_mode,
  output logic               frame_err,
  output logic               underrun,
  output logic               overflow
);

  localparam logic [5:0] ConvEdges = conv_edges(NUM_SDI);
  localparam logic [5:0] RegEdges  = 6'(RegWidth);
  localparam logic [5:0] MaxEdges  = 6'd63;

  logic csn_level, csn_rise, csn_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdo_level, sdo_rise, sdo_fall;
  logic unused_edges;

  spi_sync_edge u_sync_csn (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (spi_csn),
    .level   (csn_level),
    .rise    (csn_rise),
    .fall    (csn_fall)
  );

  spi_sync_edge u_sync_sck (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (spi_sck),
    .level   (sck_level),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge u_sync_sdo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (spi_sdo),
    .level   (sdo_level),
    .rise    (sdo_rise),
    .fall    (sdo_fall)
  );

  assign unused_edges = ^{csn_level, sck_level, sck_fall, sdo_rise, sdo_fall};

  state_t               state;
  logic [DataWidth-1:0] hold_data;
  logic                 hold_full;
  logic                 loaded;
  logic [DataWidth-1:0] shift_out;
  logic [DataWidth-1:0] shifted;
  logic [RegWidth-1:0]  shift_in;
  logic [5:0]           edge_cnt;
  logic [DataWidth-1:0] m_tdata;
  logic                 m_tvalid;

  assign shifted       = shift_out << NUM_SDI;
  assign s_axis.tready = ~hold_full;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tvalid = m_tvalid;

  // A word is consumed only if it was actually loaded at the start of this frame, so a word
  // accepted mid-frame waits for the next conversion frame instead of being silently lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_full <= 1'b0;
      loaded    <= 1'b0;
      shift_out <= '0;
      shift_in  <= '0;
      edge_cnt  <= '0;
      spi_sdi   <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      reg_mode  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;

      if (m_tvalid && m_axis.tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (csn_fall) begin
            state    <= ACTIVE;
            edge_cnt <= '0;
            shift_in <= '0;
            if (hold_full && !reg_mode) begin
              shift_out <= hold_data;
              spi_sdi   <= hold_data[DataWidth-1 -: NUM_SDI];
              loaded    <= 1'b1;
            end else begin
              shift_out <= '0;
              spi_sdi   <= '0;
              loaded    <= 1'b0;
            end
          end
        end

        ACTIVE: begin
          if (csn_rise) begin
            state   <= CLASSIFY;
            spi_sdi <= '0;
          end else if (sck_rise) begin
            if (edge_cnt != MaxEdges) begin
              edge_cnt <= edge_cnt + 6'd1;
            end
            shift_in  <= {shift_in[RegWidth-2:0], sdo_level};
            shift_out <= shifted;
            spi_sdi   <= shifted[DataWidth-1 -: NUM_SDI];
          end
        end

        CLASSIFY: begin
          state <= IDLE;
          if (edge_cnt == ConvEdges && !reg_mode) begin
            if (loaded) begin
              hold_full <= 1'b0;
            end else begin
              underrun <= 1'b1;
            end
          end else if (edge_cnt == RegEdges) begin
            // A handshake in this same cycle frees the slot, so the new word replaces it.
            if (!m_tvalid || m_axis.tready) begin
              m_tdata  <= {8'h00, shift_in};
              m_tvalid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            if (shift_in == ExitReg) begin
              reg_mode <= 1'b0;
            end else if (shift_in[RegWidth-1 -: 3] == RegModeEnter) begin
              reg_mode <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      if (s_axis.tvalid && !hold_full) begin
        hold_data <= s_axis.tdata;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
